// File: rtl/ysyx_22041071_opnd_issue_pkg.sv
// Shared constants and helpers for the ysyx_22041071 operand-issue stage.
// Register index width, default data width and base opcodes.
// No state; pure declarations.
package ysyx_22041071_opnd_issue_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic logic idx_match(input logic we, input reg_idx_t a, input reg_idx_t b);
        return we && (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/ysyx_22041071_fwd_mux.sv
// Single-slot operand selector: immediate, x0, youngest forward, WB write-through, regfile.
// Latency: combinational.
// Backpressure: raises hazard when the winning forward source is not yet final.
module ysyx_22041071_fwd_mux
    import ysyx_22041071_opnd_issue_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NFWD = 3
) (
    input  logic                   rs_use,
    input  logic [REG_IDX_W-1:0]   rs,
    input  logic [XLEN-1:0]        imm,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*5-1:0]      fwd_rd,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic [NFWD-1:0]        fwd_rdy,
    input  logic                   wb_we,
    input  logic [REG_IDX_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic [XLEN-1:0]        rf_data,
    output logic [XLEN-1:0]        opnd,
    output logic                   hazard
);

    logic            found;
    logic            sel_rdy;
    logic [XLEN-1:0] sel_data;

    // First match from index 0 wins, so a younger not-ready source blocks older ready ones.
    always_comb begin
        found    = 1'b0;
        sel_rdy  = 1'b1;
        sel_data = '0;
        for (int k = 0; k < NFWD; k++) begin
            if (!found && fwd_we[k] && (fwd_rd[5*k +: 5] == rs)) begin
                found    = 1'b1;
                sel_rdy  = fwd_rdy[k];
                sel_data = fwd_data[XLEN*k +: XLEN];
            end
        end
    end

    always_comb begin
        opnd   = rf_data;
        hazard = 1'b0;
        if (!rs_use) begin
            opnd = imm;
        end else if (rs == '0) begin
            opnd = '0;
        end else if (found) begin
            opnd   = sel_data;
            hazard = !sel_rdy;
        end else if (idx_match(wb_we, wb_rd, rs)) begin
            opnd = wb_data;
        end
    end

endmodule

// File: rtl/ysyx_22041071_opnd_issue.sv
// Operand-read/issue stage: register file, forwarding, hazard stall, registered bundle to EX.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: in_ready drops on hazard, flush, or a held output not taken by EX.
module ysyx_22041071_opnd_issue
    import ysyx_22041071_opnd_issue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NRD   = 2,
    parameter int NFWD  = 3,
    parameter int TAG_W = 96
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NRD*5-1:0]       in_rs,
    input  logic [NRD-1:0]         in_rs_use,
    input  logic [NRD*XLEN-1:0]    in_rs_imm,
    input  logic [4:0]             in_rd,
    input  logic                   in_rd_we,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*5-1:0]      fwd_rd,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic [NFWD-1:0]        fwd_rdy,
    input  logic                   wb_we,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NRD*XLEN-1:0]    out_opnd,
    output logic [4:0]             out_rd,
    output logic                   out_rd_we,
    output logic [TAG_W-1:0]       out_tag,
    input  logic [4:0]             dbg_addr,
    output logic [XLEN-1:0]        dbg_data,
    output logic [31:0]            stall_cnt
);

    logic [XLEN-1:0]     rf [32];
    logic [NRD-1:0]      slot_haz;
    logic [NRD*XLEN-1:0] opnd_nxt;
    logic                hazard;
    logic                load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) rf[r] <= '0;
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    for (genvar i = 0; i < NRD; i++) begin : g_slot
        ysyx_22041071_fwd_mux #(
            .XLEN (XLEN),
            .NFWD (NFWD)
        ) u_fwd_mux (
            .rs_use   (in_rs_use[i]),
            .rs       (in_rs[5*i +: 5]),
            .imm      (in_rs_imm[XLEN*i +: XLEN]),
            .fwd_we   (fwd_we),
            .fwd_rd   (fwd_rd),
            .fwd_data (fwd_data),
            .fwd_rdy  (fwd_rdy),
            .wb_we    (wb_we),
            .wb_rd    (wb_rd),
            .wb_data  (wb_data),
            .rf_data  (rf[in_rs[5*i +: 5]]),
            .opnd     (opnd_nxt[XLEN*i +: XLEN]),
            .hazard   (slot_haz[i])
        );
    end

    assign hazard   = in_valid && (|slot_haz);
    assign in_ready = !hazard && !flush && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;

    // Payload fields only move on load, so a held or flushed bundle stays stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_rd_we <= 1'b0;
            out_opnd  <= '0;
            out_rd    <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_rd_we <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_rd_we <= in_rd_we;
            out_opnd  <= opnd_nxt;
            out_rd    <= in_rd;
            out_tag   <= in_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_opnd_issue.sv
// Directed bench for ysyx_22041071_opnd_issue with hand-computed expectations.
module tb_ysyx_22041071_opnd_issue;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [9:0]   in_rs;
    logic [1:0]   in_rs_use;
    logic [127:0] in_rs_imm;
    logic [4:0]   in_rd;
    logic         in_rd_we;
    logic [95:0]  in_tag;
    logic [2:0]   fwd_we;
    logic [14:0]  fwd_rd;
    logic [191:0] fwd_data;
    logic [2:0]   fwd_rdy;
    logic         wb_we;
    logic [4:0]   wb_rd;
    logic [63:0]  wb_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_opnd;
    logic [4:0]   out_rd;
    logic         out_rd_we;
    logic [95:0]  out_tag;
    logic [4:0]   dbg_addr;
    logic [63:0]  dbg_data;
    logic [31:0]  stall_cnt;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ysyx_22041071_opnd_issue #(.XLEN(64), .NRD(2), .NFWD(3), .TAG_W(96)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rs_use(in_rs_use), .in_rs_imm(in_rs_imm),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_tag(in_tag),
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opnd(out_opnd), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_tag(out_tag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .stall_cnt(stall_cnt)
    );

    task automatic idle();
        in_valid  = 1'b0;
        in_rs     = '0;
        in_rs_use = '0;
        in_rs_imm = '0;
        in_rd     = '0;
        in_rd_we  = 1'b0;
        in_tag    = '0;
        fwd_we    = '0;
        fwd_rd    = '0;
        fwd_data  = '0;
        fwd_rdy   = 3'b111;
        wb_we     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        flush     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(); out_ready = 1'b1; dbg_addr = '0;
        #12;
        @(negedge clk); reset = 1'b1;
        step();
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 64'h77;
        step();
        wb_we = 1'b0; dbg_addr = 5'd4; #1;
        total++; if (dbg_data !== 64'h77) $display("FAIL rf_write x4: got %h exp %h", dbg_data, 64'h77); else passed++;
        // get a held bundle and a nonzero stall count before resetting mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_rs_use = 2'b00; in_tag = 96'h5;
        step();
        in_rs = {5'd0, 5'd9}; in_rs_use = 2'b01; fwd_we = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd9}; fwd_rdy = 3'b110;
        step(); step();
        total++; if (stall_cnt !== 32'd2) $display("FAIL pre_reset stall_cnt: got %0d exp 2", stall_cnt); else passed++;
        @(negedge clk); reset = 1'b0; #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b exp 0", out_valid); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL reset stall_cnt: got %0d exp 0", stall_cnt); else passed++;
        total++; if (out_tag !== 96'd0) $display("FAIL reset out_tag: got %h exp 0", out_tag); else passed++;
        for (int a = 0; a < 32; a++) begin
            dbg_addr = a[4:0]; #1;
            total++; if (dbg_data !== 64'd0) $display("FAIL reset dbg_data[%0d]: got %h exp 0", a, dbg_data); else passed++;
        end
        idle(); out_ready = 1'b1;
        @(negedge clk); reset = 1'b1;
        step();
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 64'd5;
        step();
        wb_we = 1'b0; dbg_addr = 5'd0; #1;
        total++; if (dbg_data !== 64'd0) $display("FAIL x0_write dbg_data: got %h exp 0", dbg_data); else passed++;
    endtask

    task automatic test_fwd_priority();
        idle(); out_ready = 1'b1; step();
        in_valid = 1'b1; in_rs = {5'd0, 5'd7}; in_rs_use = 2'b11;
        in_rd = 5'd10; in_rd_we = 1'b1; in_tag = 96'h1;
        fwd_we = 3'b111; fwd_rd = {5'd7, 5'd7, 5'd7}; fwd_data = {64'd33, 64'd22, 64'd11}; fwd_rdy = 3'b111;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL fwd in_ready: got %b exp 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL fwd out_valid: got %b exp 1", out_valid); else passed++;
        total++; if (out_opnd[63:0] !== 64'd11) $display("FAIL fwd youngest opnd0: got %0d exp 11", out_opnd[63:0]); else passed++;
        total++; if (out_opnd[127:64] !== 64'd0) $display("FAIL fwd x0 opnd1: got %0d exp 0", out_opnd[127:64]); else passed++;
        total++; if (out_rd !== 5'd10 || out_rd_we !== 1'b1) $display("FAIL fwd rd: got %0d/%b exp 10/1", out_rd, out_rd_we); else passed++;
        total++; if (out_tag !== 96'h1) $display("FAIL fwd tag: got %h exp 1", out_tag); else passed++;
        in_valid = 1'b1; fwd_we = 3'b110; in_rs_use = 2'b01; in_rs_imm = {64'h55, 64'h0}; in_tag = 96'h2;
        step();
        in_valid = 1'b0;
        total++; if (out_opnd[63:0] !== 64'd22) $display("FAIL fwd middle opnd0: got %0d exp 22", out_opnd[63:0]); else passed++;
        total++; if (out_opnd[127:64] !== 64'h55) $display("FAIL fwd imm opnd1: got %h exp 55", out_opnd[127:64]); else passed++;
    endtask

    task automatic test_load_use();
        idle(); out_ready = 1'b1; step();
        in_valid = 1'b1; in_rs = {5'd5, 5'd0}; in_rs_use = 2'b10; in_tag = 96'h3;
        fwd_we = 3'b101; fwd_rd = {5'd5, 5'd0, 5'd5}; fwd_rdy = 3'b110; fwd_data = {64'h99, 64'h0, 64'h0};
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL load_use in_ready c0: got %b exp 0", in_ready); else passed++;
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL load_use in_ready c1: got %b exp 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL load_use bubble out_valid: got %b exp 0", out_valid); else passed++;
        step();
        total++; if (stall_cnt !== 32'd2) $display("FAIL load_use stall_cnt: got %0d exp 2", stall_cnt); else passed++;
        fwd_rdy = 3'b111; fwd_data = {64'h99, 64'h0, 64'hABCD};
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL load_use released in_ready: got %b exp 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL load_use issue out_valid: got %b exp 1", out_valid); else passed++;
        total++; if (out_opnd[127:64] !== 64'hABCD) $display("FAIL load_use opnd1: got %h exp abcd", out_opnd[127:64]); else passed++;
        total++; if (stall_cnt !== 32'd2) $display("FAIL load_use stall_cnt hold: got %0d exp 2", stall_cnt); else passed++;
    endtask

    task automatic test_write_through();
        idle(); out_ready = 1'b1; step();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 64'h1234;
        in_valid = 1'b1; in_rs = {5'd0, 5'd3}; in_rs_use = 2'b01;
        step();
        wb_we = 1'b0;
        total++; if (out_opnd[63:0] !== 64'h1234) $display("FAIL write_through opnd0: got %h exp 1234", out_opnd[63:0]); else passed++;
        dbg_addr = 5'd3; #1;
        total++; if (dbg_data !== 64'h1234) $display("FAIL write_through dbg x3: got %h exp 1234", dbg_data); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (out_opnd[63:0] !== 64'h1234) $display("FAIL rf_read opnd0: got %h exp 1234", out_opnd[63:0]); else passed++;
    endtask

    task automatic test_backpressure();
        idle(); out_ready = 1'b1; step();
        out_ready = 1'b0; in_valid = 1'b1; in_rs_imm = {64'hB1, 64'hA1}; in_tag = 96'hA;
        step();
        in_rs_imm = {64'hB2, 64'hA2}; in_tag = 96'hB;
        for (int c = 0; c < 3; c++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL bp in_ready c%0d: got %b exp 0", c, in_ready); else passed++;
            total++; if (out_valid !== 1'b1 || out_tag !== 96'hA || out_opnd[63:0] !== 64'hA1)
                $display("FAIL bp hold c%0d: got %b/%h/%h exp 1/a/a1", c, out_valid, out_tag, out_opnd[63:0]); else passed++;
            step();
        end
        out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp release in_ready: got %b exp 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_tag !== 96'hB || out_opnd[63:0] !== 64'hA2)
            $display("FAIL bp next bundle: got %b/%h/%h exp 1/b/a2", out_valid, out_tag, out_opnd[63:0]); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL bp drain out_valid: got %b exp 0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        idle(); out_ready = 1'b0;
        in_valid = 1'b1; in_rd = 5'd6; in_rd_we = 1'b1; in_tag = 96'hC;
        step();
        in_tag = 96'hD; flush = 1'b1; #1;
        total++; if (out_valid !== 1'b1) $display("FAIL flush pre out_valid: got %b exp 1", out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL flush in_ready: got %b exp 0", in_ready); else passed++;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) $display("FAIL flush out_valid: got %b exp 0", out_valid); else passed++;
        total++; if (out_rd_we !== 1'b0) $display("FAIL flush out_rd_we: got %b exp 0", out_rd_we); else passed++;
        total++; if (out_tag === 96'hD) $display("FAIL flush consumed input: got tag %h exp not d", out_tag); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL flush after out_valid: got %b exp 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        idle(); out_ready = 1'b1; step();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_tag = 96'(i); in_rs_imm = {64'h0, 64'(i * 3)};
            step();
            total++; if (out_valid !== 1'b1 || out_tag !== 96'(i) || out_opnd[63:0] !== 64'(i * 3))
                $display("FAIL b2b bundle %0d: got %b/%h/%h exp 1/%h/%h", i, out_valid, out_tag, out_opnd[63:0], i, i * 3); else passed++;
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b drain out_valid: got %b exp 0", out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_write_through();
        test_backpressure();
        test_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
